// File: rtl/counter_step_ctrl_if.sv
// Button/strobe bundle between the operator panel and the step-counter control.
// Raw buttons flow toward the controller; strobes and mode flag flow back.
interface counter_step_ctrl_if;
  logic btn_add;
  logic btn_minus;
  logic btn_pause;
  logic inc;
  logic dec;
  logic running;

  // panel / testbench side: drives buttons, watches strobes
  modport master (
    output btn_add, btn_minus, btn_pause,
    input  inc, dec, running
  );

  // controller side
  modport slave (
    input  btn_add, btn_minus, btn_pause,
    output inc, dec, running
  );
endinterface

// File: rtl/counter_step_ctrl.sv
// Control front-end for the up/down step counter: per-button sync + debounce +
// rising-edge detect, then a RUN/HOLD mode machine that issues one-cycle
// inc/dec strobes (periodic ticks in RUN, operator steps in HOLD).

// One button lane: 2-flop synchronizer, consecutive-sample debounce filter and
// press (rising edge of the filtered level) detector.
module counter_step_btn #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1, s2;
  logic          filt, filt_d;
  logic [CW-1:0] cnt;

  // two-flop synchronizer for the asynchronous raw level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // accept a new level only after DB_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (s2 == filt) begin
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= s2;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

  // one-cycle delayed copy of the filtered level for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) filt_d <= 1'b0;
    else        filt_d <= filt;
  end

  // press only; releases produce nothing
  assign press = filt & ~filt_d;
endmodule

module counter_step_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int TICK_DIV  = 8
) (
  input logic                clk,
  input logic                reset,
  counter_step_ctrl_if.slave bus
);
  localparam int NUM_BTN   = 3;
  localparam int BTN_ADD   = 0;
  localparam int BTN_MINUS = 1;
  localparam int BTN_PAUSE = 2;
  localparam int PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } mode_e;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;

  assign raw = {bus.btn_pause, bus.btn_minus, bus.btn_add};

  // identical conditioning lane per button
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    counter_step_btn #(
      .DB_CYCLES(DB_CYCLES)
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[g]),
      .press(press[g])
    );
  end

  logic add_p, minus_p, pause_p;
  assign add_p   = press[BTN_ADD];
  assign minus_p = press[BTN_MINUS];
  assign pause_p = press[BTN_PAUSE];

  mode_e         mode;
  logic [PW-1:0] pre;
  logic          inc_q;
  logic          dec_q;

  // mode machine with registered strobes; a pause press overrides any tick
  // or step that would otherwise fire on the same edge, and restarts the
  // prescaler so the first RUN tick lands TICK_DIV edges after entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode  <= RUN;
      pre   <= '0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else if (pause_p) begin
      mode  <= (mode == RUN) ? HOLD : RUN;
      pre   <= '0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      case (mode)
        RUN: begin
          pre   <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
          inc_q <= (pre == PRE_LAST);
          dec_q <= 1'b0;
        end
        default: begin
          // simultaneous add+minus cancel each other
          pre   <= '0;
          inc_q <= add_p & ~minus_p;
          dec_q <= minus_p & ~add_p;
        end
      endcase
    end
  end

  assign bus.inc     = inc_q;
  assign bus.dec     = dec_q;
  assign bus.running = (mode == RUN);
endmodule

// File: tb/tb_counter_step_ctrl.sv
// Bench for counter_step_ctrl: directed scenarios plus random button activity,
// checked every cycle against a window-based behavioural model, with literal
// timing expectations for the key scenarios.
module tb_counter_step_ctrl;
  localparam int DB = 4;
  localparam int TD = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  counter_step_ctrl_if bus ();

  counter_step_ctrl #(
    .DB_CYCLES(DB),
    .TICK_DIV (TD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Filter rule: the accepted level flips when the last DB synchronized
  // samples all disagree with it. Synchronized sample = raw from two edges ago.
  bit   m_s1[3], m_s2[3], m_filt[3], m_rose[3];
  int   dq[3][$];
  bit   m_run = 1'b1, m_inc = 1'b0, m_dec = 1'b0, all_diff;
  int   mk = 0, run_start = 0;
  logic [2:0] rv;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_filt[b] = 0; m_rose[b] = 0;
        dq[b].delete();
      end
      m_run = 1; m_inc = 0; m_dec = 0; mk = 0; run_start = 0;
    end else begin
      mk++;
      rv = {bus.btn_pause, bus.btn_minus, bus.btn_add};
      if (m_rose[2]) begin
        m_run = !m_run; m_inc = 0; m_dec = 0; run_start = mk;
      end else if (m_run) begin
        m_inc = ((mk - run_start) % TD) == 0;
        m_dec = 0;
      end else begin
        m_inc = m_rose[0] && !m_rose[1];
        m_dec = m_rose[1] && !m_rose[0];
      end
      for (int b = 0; b < 3; b++) begin
        dq[b].push_back(int'(m_s2[b]));
        if (dq[b].size() > DB) void'(dq[b].pop_front());
        m_rose[b] = 0;
        if (dq[b].size() == DB) begin
          all_diff = 1;
          for (int i = 0; i < DB; i++) if (dq[b][i] == int'(m_filt[b])) all_diff = 0;
          if (all_diff) begin
            m_rose[b] = !m_filt[b];
            m_filt[b] = !m_filt[b];
          end
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = rv[b];
      end
    end
  end

  // edges since reset release, for literal timing expectations
  int ecnt = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // ---------------- compare + event log ----------------
  int inc_log[$];
  int dec_log[$];
  int fall_edge = -1, rise_edge = -1;
  bit prev_run = 1'b1;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      chk("inc",     bus.inc,     m_inc);
      chk("dec",     bus.dec,     m_dec);
      chk("running", bus.running, m_run);
      chk("excl",    bus.inc & bus.dec, 0);
      if (bus.inc === 1'b1) inc_log.push_back(ecnt);
      if (bus.dec === 1'b1) dec_log.push_back(ecnt);
      if (prev_run && bus.running === 1'b0) fall_edge = ecnt;
      if (!prev_run && bus.running === 1'b1) rise_edge = ecnt;
      prev_run = (bus.running === 1'b1);
    end else begin
      prev_run = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic btns(bit a, bit m, bit p);
    bus.btn_add = a; bus.btn_minus = m; bus.btn_pause = p;
  endtask

  task automatic clr_log();
    inc_log.delete(); dec_log.delete();
  endtask

  int e0;

  initial begin
    btns(0, 0, 0);
    cyc(3);
    chk("rst_inc",     bus.inc,     0);
    chk("rst_dec",     bus.dec,     0);
    chk("rst_running", bus.running, 1);
    reset = 1'b1;

    // idle RUN: ticks at edges 8,16,24
    cyc(30);
    chk("tick_count", inc_log.size(), 3);
    if (inc_log.size() == 3) begin
      chk("tick_1", inc_log[0], 8);
      chk("tick_2", inc_log[1], 16);
      chk("tick_3", inc_log[2], 24);
    end
    chk("idle_dec", dec_log.size(), 0);

    // pause press sampled first at edge 34 -> HOLD at edge 40, tick at 40 suppressed
    cyc(3);
    btns(0, 0, 1);
    cyc(20);
    btns(0, 0, 0);
    cyc(20);
    chk("pause_fall_edge", fall_edge, 40);
    chk("pause_tick_count", inc_log.size(), 4);
    chk("hold_running", bus.running, 0);

    // HOLD: clean add held 50 cycles -> single inc 6 edges after first sample
    clr_log();
    e0 = ecnt + 1;
    btns(1, 0, 0);
    cyc(50);
    btns(0, 0, 0);
    cyc(15);
    chk("add_count", inc_log.size(), 1);
    if (inc_log.size() == 1) chk("add_edge", inc_log[0], e0 + 6);

    // HOLD: minus press
    clr_log();
    e0 = ecnt + 1;
    btns(0, 1, 0);
    cyc(20);
    btns(0, 0, 0);
    cyc(15);
    chk("minus_count", dec_log.size(), 1);
    if (dec_log.size() == 1) chk("minus_edge", dec_log[0], e0 + 6);
    chk("minus_no_inc", inc_log.size(), 0);

    // HOLD: bounce add every 2 cycles for 20 cycles, then settle high
    clr_log();
    for (int i = 0; i < 10; i++) begin
      btns(i % 2 == 0, 0, 0);
      cyc(2);
    end
    e0 = ecnt + 1;
    btns(1, 0, 0);
    cyc(20);
    btns(0, 0, 0);
    cyc(15);
    chk("bounce_count", inc_log.size(), 1);
    if (inc_log.size() == 1) chk("bounce_edge", inc_log[0], e0 + 6);

    // HOLD: add and minus together cancel
    clr_log();
    btns(1, 1, 0);
    cyc(30);
    btns(0, 0, 0);
    cyc(15);
    chk("both_inc", inc_log.size(), 0);
    chk("both_dec", dec_log.size(), 0);

    // second pause -> RUN, first tick 8 edges after the toggle edge
    clr_log();
    e0 = ecnt + 1;
    btns(0, 0, 1);
    cyc(10);
    btns(0, 0, 0);
    cyc(20);
    chk("resume_rise_edge", rise_edge, e0 + 6);
    if (inc_log.size() > 0) chk("resume_first_tick", inc_log[0], e0 + 14);
    else chk("resume_first_tick", 0, e0 + 14);

    // enter HOLD, then reset 3 edges into an add debounce
    btns(0, 0, 1);
    cyc(10);
    btns(0, 0, 0);
    cyc(10);
    chk("hold_again", bus.running, 0);
    btns(1, 0, 0);
    cyc(3);
    reset = 1'b0;
    #1;
    chk("arst_running", bus.running, 1);
    chk("arst_inc",     bus.inc,     0);
    chk("arst_dec",     bus.dec,     0);
    cyc(2);
    clr_log();
    reset = 1'b1;
    cyc(30);
    // add still held but we are in RUN: only periodic ticks
    chk("post_rst_count", inc_log.size(), 3);
    if (inc_log.size() == 3) chk("post_rst_first", inc_log[0], 8);
    btns(0, 0, 0);
    cyc(10);

    // random button activity with occasional resets
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
      end
      btns(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
      cyc($urandom_range(1, 12));
    end
    btns(0, 0, 0);
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
